ser_word_tx: RTL
================

# ser_word_tx

Parallel-to-serial word transmitter that feeds the 4-bit serial-in/parallel-out shift stage. It accepts parallel words over a valid/ready handshake, buffers one word, and emits each word MSB-first as a serial bit (SER_DO) plus a per-bit shift enable (SER_EN), at one bit per DIV clocks. WORD_DONE marks the final bit of each word, so the downstream parallel output holds the complete word after the next clock edge.

## Interface
- WIDTH, 4: bits per word; must be ≥2; matches downstream register width.
- DIV, 1: clocks per serial bit; must be ≥1.
- RST  in  1  asynchronous reset, active-high
- CLK  in  1  clock, rising edge
- DIN  in  WIDTH  parallel word to send
- DIN_VLD  in  1  DIN valid
- DIN_RDY  out  1  block can accept DIN this cycle
- SER_DO  out  1  serial data bit, MSB first; drives downstream IN
- SER_EN  out  1  one-cycle shift strobe per bit; drives downstream EN
- WORD_DONE  out  1  one-cycle pulse coincident with the last SER_EN of a word
- BUSY  out  1  shifter active or hold register occupied

## Operation
- Storage:
  - shifter: WIDTH bits, bit counter, divider counter.
  - hold register: 1 word plus hold_full flag.
- Handshake:
  - Transfer occurs when DIN_VLD && DIN_RDY at a rising edge.
  - DIN_RDY = !hold_full && !RST.
  - DIN_VLD may drop without a transfer; there is no obligation to hold it.
- States:
  - IDLE: shifter empty.
  - SHIFT: shifter sending.
- Routing of an accepted word:
  - If state is IDLE, or the current cycle is the last-bit strobe with hold empty, the word loads directly into the shifter.
  - Otherwise it goes to hold.
- At the last-bit strobe:
  - If hold_full: hold moves to the shifter, hold_full clears, state stays SHIFT.
  - Else if a word is accepted this cycle: it loads, state stays SHIFT.
  - Else: go to IDLE.
- Bit timing:
  - Divider counts 0..DIV-1 from each shifter load and from each bit strobe.
  - SER_EN = (state==SHIFT) && (div_cnt==DIV-1).
  - On SER_EN the shifter shifts left and the bit counter increments.
  - The last-bit strobe is SER_EN && bit_cnt==WIDTH-1.
- Outputs:
  - SER_DO = shifter MSB while in SHIFT, 0 in IDLE.
  - SER_DO is stable for the whole bit period.
  - WORD_DONE = last-bit strobe.
  - BUSY = (state==SHIFT) || hold_full.
- Reset (asynchronous, any time, including mid-word):
  - State IDLE, all counters 0, shifter 0, hold_full 0.
  - SER_DO=0, SER_EN=0, WORD_DONE=0, BUSY=0, DIN_RDY=0 while RST is high.
  - A partially sent word is discarded; no WORD_DONE is issued for it.

## Timing
- Load at edge t: SER_DO = DIN[WIDTH-1] in cycle t+1.
- First SER_EN in cycle t+DIV; the bit-k strobe (k from 0) is in cycle t+(k+1)·DIV.
- WORD_DONE in cycle t+WIDTH·DIV.
  - Downstream register holds the complete word after that cycle's closing edge.
- Back-to-back words: no idle cycle; the next word's MSB is on SER_DO in the cycle after WORD_DONE.
- Sustained throughput: one word per WIDTH·DIV clocks.
- Capacity: 2 words (shifter + hold). With both occupied, DIN_RDY is low until the last-bit strobe edge.
- DIV=1: SER_EN is high every cycle during SHIFT.

## Structure
- Shared package/header holds:
  - state encodings ST_IDLE=1'b0, ST_SHIFT=1'b1;
  - a clog2 function used to size bit_cnt and div_cnt.
- Sub-module bit_tick_gen: divider counter with synchronous restart on load, producing the tick for SER_EN.
- Top level holds the FSM, hold register and shifter.

## Test plan
- Reset, then DIN=4'b1011 with DIN_VLD for 1 cycle, DIV=1:
  - SER_DO sequence 1,0,1,1 with SER_EN high for 4 cycles.
  - WORD_DONE on the 4th.
  - Downstream OUT=4'b1011 on the next cycle.
- DIV=3, DIN=4'b0110:
  - SER_EN pulses spaced 3 cycles apart, first pulse 3 cycles after load.
  - WORD_DONE 12 cycles after load.
- DIN_VLD held high with words 4'hA, 4'h5, 4'hF, DIV=1:
  - DIN_RDY drops after the second accept.
  - Stream 1010_0101_1111 with no gaps.
  - WORD_DONE every 4 cycles.
- Word accepted in the same cycle as the last-bit strobe with hold empty: word loads directly, no gap cycle, hold_full stays 0.
- RST pulsed after 2 bits of 4'b1100 with a word in hold:
  - All outputs 0, hold cleared, no WORD_DONE.
  - After release, a new word 4'h3 sends cleanly.
- DIN_VLD toggling with DIN_RDY low: no word accepted, stream unaffected.

Source files
------------

// File: rtl/ser_word_tx_pkg.sv
// Shared types and helpers for the serial word transmitter.
// Holds the FSM state encoding and a width helper for counters.
package ser_word_tx_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   // Bits needed to count 0..n-1, never less than one bit.
   function automatic int clog2(input int n);
      int r;
      r = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/ser_word_tx_bit_tick_gen.sv
// Bit-period divider for the serial transmitter.
// Produces one tick every DIV clocks while running; restarts on load.
module bit_tick_gen
   import ser_word_tx_pkg::*;
#(
   parameter int DIV = 1
) (
   input  logic CLK,
   input  logic RST,
   input  logic restart,
   input  logic run,
   output logic tick
);

   localparam int DW = clog2(DIV);
   localparam logic [DW-1:0] LAST = DW'(DIV - 1);

   logic [DW-1:0] div_cnt;

   assign tick = run && (div_cnt == LAST);

   // Count clocks within a bit; a load or a strobe begins a new bit period.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         div_cnt <= '0;
      end else if (restart || tick) begin
         div_cnt <= '0;
      end else if (run) begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/ser_word_tx.sv
// Parallel-to-serial word transmitter, MSB first, with one-word hold buffer.
// Feeds a downstream SIPO register through SER_DO/SER_EN.
module ser_word_tx
   import ser_word_tx_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int DIV   = 1
) (
   input  logic             RST,
   input  logic             CLK,
   input  logic [WIDTH-1:0] DIN,
   input  logic             DIN_VLD,
   output logic             DIN_RDY,
   output logic             SER_DO,
   output logic             SER_EN,
   output logic             WORD_DONE,
   output logic             BUSY
);

   localparam int BW = clog2(WIDTH);
   localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] shifter;
   logic [WIDTH-1:0] hold;
   logic [WIDTH-1:0] load_word;
   logic             hold_full;
   logic [BW-1:0]    bit_cnt;
   logic             accept;
   logic             tick;
   logic             last;
   logic             load;
   logic             to_hold;

   assign DIN_RDY   = !hold_full && !RST;
   assign accept    = DIN_VLD && DIN_RDY;
   assign last      = tick && (bit_cnt == LAST_BIT);
   assign SER_EN    = tick;
   assign WORD_DONE = last;
   assign SER_DO    = (state == ST_SHIFT) && shifter[WIDTH-1];
   assign BUSY      = (state == ST_SHIFT) || hold_full;

   bit_tick_gen #(
      .DIV (DIV)
   ) u_tick (
      .CLK     (CLK),
      .RST     (RST),
      .restart (load),
      .run     (state == ST_SHIFT),
      .tick    (tick)
   );

   // State register.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // Route accepted words to shifter or hold; chain words at the last bit.
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      to_hold   = 1'b0;
      load_word = DIN;
      unique case (state)
         ST_IDLE: begin
            if (accept) begin
               load      = 1'b1;
               state_nxt = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (last) begin
               if (hold_full) begin
                  load      = 1'b1;
                  load_word = hold;
               end else if (accept) begin
                  load = 1'b1;
               end else begin
                  state_nxt = ST_IDLE;
               end
            end else if (accept) begin
               to_hold = 1'b1;
            end
         end
      endcase
   end

   // Hold buffer: filled while shifting, drained at the last-bit strobe.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         hold      <= '0;
         hold_full <= 1'b0;
      end else begin
         if (last && hold_full) hold_full <= 1'b0;
         if (to_hold) begin
            hold      <= DIN;
            hold_full <= 1'b1;
         end
      end
   end

   // Shifter and bit counter: load a word, or shift one bit per strobe.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         shifter <= '0;
         bit_cnt <= '0;
      end else if (load) begin
         shifter <= load_word;
         bit_cnt <= '0;
      end else if (tick) begin
         shifter <= {shifter[WIDTH-2:0], 1'b0};
         bit_cnt <= last ? '0 : bit_cnt + 1'b1;
      end
   end

endmodule
